// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes, drain FSM state encoding and a response helper
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ADDR    = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam logic [1:0] ST_BACKOFF = 2'd3;
    function automatic logic resp_ok(input logic [1:0] resp);
        return resp == RESP_OKAY;
    endfunction
endpackage

// File: rtl/axil_drain_obuf.sv
// axil_drain_obuf: small synchronous FIFO holding drained words; head is zero while empty
module axil_drain_obuf
    import axi_lite_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_data,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    logic          w_pop;
    assign o_valid = r_count != '0;
    assign w_pop   = i_pop && o_valid;
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_count;
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(i_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/axil_fifo_drain_master.sv
// axil_fifo_drain_master: AXI4-Lite read master draining a FIFO slave into an AXI-Stream output.
// Define AXIL_DRAIN_ERRCNT_EN to build the saturating non-OKAY response counter on err_cnt.
module axil_fifo_drain_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int RD_ADDR    = 0,
    parameter int OUT_DEPTH  = 4,
    parameter int RETRY_WAIT = 8
) (
    input  logic                  rd_clk,
    input  logic                  S_AXI_ARESETN,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  idle,
    output logic [15:0]           err_cnt
);
    localparam int CW = $clog2(OUT_DEPTH) + 1;
    localparam int WW = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT + 1) : 1;
    // The IDLE decision cycle is the last of the RETRY_WAIT quiet cycles, so backoff itself lasts one less
    localparam logic [WW-1:0] WAIT_LOAD = WW'((RETRY_WAIT > 1) ? RETRY_WAIT - 1 : 0);
    logic [1:0]    r_state;
    logic [WW-1:0] r_wait;
    logic [CW-1:0] w_count;
    logic          w_rsp, w_push;
    assign w_rsp         = r_state == ST_RESP && M_AXI_RVALID;
    assign w_push        = w_rsp && resp_ok(M_AXI_RRESP);
    assign M_AXI_ARADDR  = ADDR_WIDTH'(RD_ADDR);
    assign M_AXI_ARVALID = r_state == ST_ADDR;
    assign M_AXI_RREADY  = r_state == ST_RESP;
    assign idle          = r_state == ST_IDLE && w_count == '0;
    always_ff @(posedge rd_clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (enable && w_count != CW'(OUT_DEPTH)) r_state <= ST_ADDR;
                ST_ADDR: if (M_AXI_ARREADY) r_state <= ST_RESP;
                ST_RESP: if (M_AXI_RVALID) begin
                    r_state <= (resp_ok(M_AXI_RRESP) || RETRY_WAIT <= 1) ? ST_IDLE : ST_BACKOFF;
                    r_wait  <= WAIT_LOAD;
                end
                default: begin
                    r_wait <= r_wait - WW'(1);
                    if (r_wait <= WW'(1)) r_state <= ST_IDLE;
                end
            endcase
        end
    end
`ifdef AXIL_DRAIN_ERRCNT_EN
    logic [15:0] r_err_cnt;
    always_ff @(posedge rd_clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_err_cnt <= '0;
        else if (w_rsp && !resp_ok(M_AXI_RRESP) && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'h0000;
`endif
    axil_drain_obuf #(.DEPTH(OUT_DEPTH), .DW(DATA_WIDTH)) u_obuf (
        .i_clk   (rd_clk),
        .i_rst_n (S_AXI_ARESETN),
        .i_push  (w_push),
        .i_data  (M_AXI_RDATA),
        .i_pop   (M_AXIS_TREADY),
        .o_data  (M_AXIS_TDATA),
        .o_valid (M_AXIS_TVALID),
        .o_count (w_count)
    );
endmodule

// File: tb/tb_axil_fifo_drain_master.sv
// tb_axil_fifo_drain_master: scoreboard bench with a reactive FIFO-slave model and stream monitor
module tb_axil_fifo_drain_master;
    import axi_lite_pkg::*;
    localparam int AW = 4;
    localparam int DW = 32;
`ifdef AXIL_DRAIN_ERRCNT_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif
    logic          rd_clk = 0, rstn = 0, enable = 0;
    logic [AW-1:0] araddr;
    logic          arvalid, arready = 1, rvalid = 0, rready, tvalid, tready = 0, idle;
    logic [DW-1:0] rdata = '0, tdata;
    logic [1:0]    rresp = '0;
    logic [15:0]   err_cnt;
    int checks = 0, errors = 0, cyc = 0, ar_count = 0, ar_rise_cyc = 0, err_cyc = 0, ar_wait = 0;
    int ar_low_until = -1;
    logic [33:0] rq[$];
    logic [31:0] sb[$];

    axil_fifo_drain_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_ADDR(0), .OUT_DEPTH(4), .RETRY_WAIT(8)) dut (
        .rd_clk(rd_clk), .S_AXI_ARESETN(rstn), .enable(enable),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
        .idle(idle), .err_cnt(err_cnt)
    );

    initial forever #5 rd_clk = ~rd_clk;
    initial forever begin
        @(posedge rd_clk);
        cyc++;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #2;
    endtask

    task automatic wait_ars(input int n);
        int k = 0;
        while (ar_count < n && k < 200) begin
            tick(1);
            k++;
        end
        chk("ar_reach", ar_count, n);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb.size() != 0 || tvalid) && k < 100) begin
            tick(1);
            k++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic add_word(input logic [1:0] resp, input logic [31:0] d);
        rq.push_back({resp, d});
        if (resp == RESP_OKAY) sb.push_back(d);
    endtask

    // FIFO slave: accepts AR, answers one cycle later; SLVERR when its queue is empty
    initial begin : slave
        logic ar_hs, r_hs;
        logic [33:0] e;
        forever begin
            @(negedge rd_clk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (r_hs && rresp != RESP_OKAY) err_cyc = cyc;
            @(posedge rd_clk);
            #1;
            if (!rstn) begin
                rvalid = 0;
                rq.delete();
            end else begin
                if (r_hs) rvalid = 0;
                if (ar_hs) begin
                    e = (rq.size() != 0) ? rq.pop_front() : {RESP_SLVERR, 32'h0};
                    rresp = e[33:32];
                    rdata = e[31:0];
                    rvalid = 1;
                    ar_count++;
                end
            end
            arready = cyc > ar_low_until;
        end
    end

    initial begin : monitor
        logic p_av = 0, p_ar = 0, p_tv = 0, p_tr = 0;
        logic [AW-1:0] p_addr = '0;
        logic [DW-1:0] p_td = '0;
        forever begin
            @(negedge rd_clk);
            if (rstn) begin
                if (p_av && !p_ar) begin
                    chk("arvalid_hold", arvalid, 1);
                    chk("araddr_hold", araddr, p_addr);
                end
                if (p_tv && !p_tr) begin
                    chk("tvalid_hold", tvalid, 1);
                    chk("tdata_hold", tdata, p_td);
                end
                if (arvalid && !p_av) ar_rise_cyc = cyc;
                if (arvalid && !arready) ar_wait++;
                if (arvalid && arready) chk("araddr", araddr, 0);
                if (tvalid && tready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stream_extra: got %h expected no word", tdata);
                    end else chk("tdata", tdata, sb.pop_front());
                end
            end
            p_av = arvalid && rstn;
            p_ar = arready;
            p_addr = araddr;
            p_tv = tvalid && rstn;
            p_tr = tready;
            p_td = tdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, wbase;
        tick(3);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err_cnt", err_cnt, 0);
        rstn = 1;
        tick(2);
        chk("idle_disabled", idle, 1);
        chk("no_ar_disabled", ar_count, 0);
        // 1: four OKAY words stream out in order
        for (int i = 1; i <= 4; i++) add_word(RESP_OKAY, 32'hA5A5_0000 + i);
        tready = 1;
        enable = 1;
        wait_ars(4);
        enable = 0;
        wait_drain();
        tick(10);
        chk("t1_ar_count", ar_count, 4);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_idle", idle, 1);
        // 2: SLVERR backoff then retry
        base = ar_count;
        add_word(RESP_SLVERR, 32'h0);
        add_word(RESP_OKAY, 32'h1234_5678);
        enable = 1;
        wait_ars(base + 2);
        enable = 0;
        chk("t2_retry_gap", ar_rise_cyc - err_cyc, 9);
        wait_drain();
        chk("t2_err_cnt", err_cnt, EXP_ERR);
        // 3: full buffer blocks AR until the consumer drains
        base = ar_count;
        tready = 0;
        for (int i = 0; i < 6; i++) add_word(RESP_OKAY, 32'hB000_0000 + i);
        enable = 1;
        tick(40);
        chk("t3_ar_full", ar_count - base, 4);
        chk("t3_arvalid_low", arvalid, 0);
        chk("t3_tvalid", tvalid, 1);
        chk("t3_tdata_head", tdata, 32'hB000_0000);
        tready = 1;
        wait_ars(base + 6);
        enable = 0;
        wait_drain();
        tick(10);
        chk("t3_ar_total", ar_count - base, 6);
        // 4: ARREADY withheld for 5 cycles
        base = ar_count;
        wbase = ar_wait;
        add_word(RESP_OKAY, 32'hC0DE_0004);
        ar_low_until = cyc + 5;
        enable = 1;
        wait_ars(base + 1);
        enable = 0;
        wait_drain();
        tick(5);
        chk("t4_wait_cycles", ar_wait - wbase, 5);
        chk("t4_single_hs", ar_count - base, 1);
        // 5: reset while in RESP with two words buffered
        base = ar_count;
        tready = 0;
        for (int i = 0; i < 3; i++) add_word(RESP_OKAY, 32'hE000_0000 + i);
        enable = 1;
        wait_ars(base + 3);
        chk("t5_pre_rready", rready, 1);
        chk("t5_pre_tvalid", tvalid, 1);
        rstn = 0;
        #1;
        chk("t5_arvalid", arvalid, 0);
        chk("t5_rready", rready, 0);
        chk("t5_tvalid", tvalid, 0);
        chk("t5_idle", idle, 1);
        sb.delete();
        enable = 0;
        tready = 1;
        tick(2);
        rstn = 1;
        tick(2);
        chk("t5_err_cleared", err_cnt, 0);
        chk("t5_idle_after", idle, 1);
        // 6: enable dropped right after the AR handshake
        base = ar_count;
        add_word(RESP_OKAY, 32'hD000_0006);
        enable = 1;
        wait_ars(base + 1);
        enable = 0;
        tick(20);
        chk("t6_single_ar", ar_count - base, 1);
        wait_drain();
        chk("t6_idle", idle, 1);
        chk("t6_arvalid", arvalid, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
